// File: rtl/line_scan_ctrl_if.sv
// Handshake and status bundle between a line-scan controller and its frame sequencer.
// The controller side uses the slave modport; the sequencer (or bench) uses master.
interface line_scan_ctrl_if;
  logic        start;
  logic        test;
  logic        abort;
  logic        end_line;
  logic        line_enb;
  logic        test_mode;
  logic [11:0] line_idx;
  logic        line_start;
  logic        frame_done;
  logic        busy;
  logic        timeout_err;

  modport master (
    output start, test, abort, end_line,
    input  line_enb, test_mode, line_idx, line_start, frame_done, busy, timeout_err
  );

  modport slave (
    input  start, test, abort, end_line,
    output line_enb, test_mode, line_idx, line_start, frame_done, busy, timeout_err
  );
endinterface

// File: rtl/line_scan_ctrl.sv
// Line-scan frame controller: walks a frame line by line, enabling the pixel counter during
// ACTIVE, inserting a fixed horizontal blank after each line, and guarding each line with a
// watchdog. All outputs come straight from flops.
module line_scan_ctrl #(
  parameter int unsigned HBLANK_CYC   = 16,
  parameter int unsigned LINES_NORMAL = 3072,
  parameter int unsigned LINES_TEST   = 8,
  parameter int unsigned TIMEOUT_CYC  = 4104
) (
  input logic             clk,
  input logic             rst_n,
  line_scan_ctrl_if.slave bus
);

  typedef enum logic [1:0] {StIdle, StActive, StBlank, StDone} state_e;

  localparam logic [11:0] LastNormal = 12'(LINES_NORMAL - 1);
  localparam logic [11:0] LastTest   = 12'(LINES_TEST - 1);
  localparam logic [7:0]  BlankLoad  = 8'(HBLANK_CYC - 1);
  localparam logic [12:0] WdLimit    = 13'(TIMEOUT_CYC - 1);

  state_e      state_q;
  logic [7:0]  blank_q;
  logic [12:0] wd_q;
  logic        test_mode_q;
  logic [11:0] line_idx_q;
  logic        line_enb_q;
  logic        line_start_q;
  logic        frame_done_q;
  logic        busy_q;
  logic        timeout_q;
  logic [11:0] last_line;

  assign last_line = test_mode_q ? LastTest : LastNormal;

  // Frame FSM; every output is set on the transition that leads into the state it belongs to.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= StIdle;
      blank_q      <= '0;
      wd_q         <= '0;
      test_mode_q  <= 1'b0;
      line_idx_q   <= '0;
      line_enb_q   <= 1'b0;
      line_start_q <= 1'b0;
      frame_done_q <= 1'b0;
      busy_q       <= 1'b0;
      timeout_q    <= 1'b0;
    end else begin
      line_start_q <= 1'b0;
      frame_done_q <= 1'b0;
      case (state_q)
        StIdle: begin
          // abort in IDLE blocks start; test is only sampled with an accepted start
          if (bus.start && !bus.abort) begin
            state_q      <= StActive;
            test_mode_q  <= bus.test;
            line_idx_q   <= '0;
            timeout_q    <= 1'b0;
            wd_q         <= '0;
            line_enb_q   <= 1'b1;
            line_start_q <= 1'b1;
            busy_q       <= 1'b1;
          end
        end
        StActive: begin
          // abort beats end_line, and end_line beats the watchdog
          if (bus.abort) begin
            state_q    <= StIdle;
            line_enb_q <= 1'b0;
            busy_q     <= 1'b0;
          end else if (bus.end_line) begin
            state_q    <= StBlank;
            blank_q    <= BlankLoad;
            line_enb_q <= 1'b0;
          end else if (wd_q == WdLimit) begin
            state_q    <= StIdle;
            line_enb_q <= 1'b0;
            busy_q     <= 1'b0;
            timeout_q  <= 1'b1;
          end else begin
            wd_q <= wd_q + 13'd1;
          end
        end
        StBlank: begin
          if (bus.abort) begin
            state_q <= StIdle;
            busy_q  <= 1'b0;
          end else if (blank_q == 8'd0) begin
            if (line_idx_q == last_line) begin
              state_q      <= StDone;
              frame_done_q <= 1'b1;
            end else begin
              state_q      <= StActive;
              line_idx_q   <= line_idx_q + 12'd1;
              wd_q         <= '0;
              line_enb_q   <= 1'b1;
              line_start_q <= 1'b1;
            end
          end else begin
            blank_q <= blank_q - 8'd1;
          end
        end
        StDone: begin
          state_q <= StIdle;
          busy_q  <= 1'b0;
        end
        default: begin
          state_q    <= StIdle;
          line_enb_q <= 1'b0;
          busy_q     <= 1'b0;
        end
      endcase
    end
  end

  assign bus.line_enb    = line_enb_q;
  assign bus.test_mode   = test_mode_q;
  assign bus.line_idx    = line_idx_q;
  assign bus.line_start  = line_start_q;
  assign bus.frame_done  = frame_done_q;
  assign bus.busy        = busy_q;
  assign bus.timeout_err = timeout_q;

endmodule

// File: tb/tb_line_scan_ctrl.sv
// Bench for line_scan_ctrl: a pixel-counter model closes the loop on end_line, a frame-level
// reference model predicts every line_start / frame_done / timeout event with its cycle, and a
// monitor pops and compares those predictions as the DUT produces them.
module tb_line_scan_ctrl;
  localparam int HBLANK = 16;
  localparam int LN     = 2;
  localparam int LT     = 8;
  localparam int TO     = 4104;

  typedef struct {
    int kind;  // 0 line_start, 1 frame_done, 2 timeout_err rise
    int cyc;
    int idx;
    int tm;
  } ev_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  line_scan_ctrl_if bus();

  line_scan_ctrl #(
    .HBLANK_CYC  (HBLANK),
    .LINES_NORMAL(LN),
    .LINES_TEST  (LT),
    .TIMEOUT_CYC (TO)
  ) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );

  always #5 clk = ~clk;

  ev_t  exp_q[$];
  int   n_cmp = 0;
  int   n_fail = 0;
  int   cyc = 0;
  int   pix = 0;
  int   line_len = 0;
  int   exp_run = -1;
  logic el_force = 1'b0;

  // free-running cycle count used as the time base for predicted events
  always @(posedge clk) cyc <= cyc + 1;

  // pixel counter model: counts while enabled, cleared while line_enb is low
  always @(posedge clk) pix <= bus.line_enb ? pix + 1 : 0;
  assign bus.end_line = el_force | (bus.line_enb && line_len != 0 && pix == line_len - 1);

  task automatic check(input string name, input int act, input int req);
    n_cmp++;
    if (act != req) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, req, cyc);
    end
  endtask

  function automatic void push(input int kind, input int c, input int idx, input int tm,
                               input int cut);
    ev_t e;
    if (c <= cut) begin
      e.kind = kind;
      e.cyc  = c;
      e.idx  = idx;
      e.tm   = tm;
      exp_q.push_back(e);
    end
  endfunction

  // monitor: pop one prediction per observed event; also length of each line_enb run
  int  mon_kind;
  ev_t mon_e;
  int  run = 0;
  bit  to_prev = 1'b0;
  always @(negedge clk) begin
    if (!rst_n) begin
      run = 0;
      to_prev = 1'b0;
    end else begin
      if (bus.line_start || bus.frame_done || (bus.timeout_err && !to_prev)) begin
        mon_kind = bus.line_start ? 0 : (bus.frame_done ? 1 : 2);
        if (exp_q.size() == 0) begin
          check("unexpected_event", mon_kind, -1);
        end else begin
          mon_e = exp_q.pop_front();
          check("event_kind", mon_kind, mon_e.kind);
          check("event_cycle", cyc, mon_e.cyc);
          check("event_idx", int'(bus.line_idx), mon_e.idx);
          check("event_mode", int'(bus.test_mode), mon_e.tm);
        end
      end
      to_prev = bus.timeout_err;
      if (bus.line_enb) begin
        run++;
      end else begin
        if (run > 0 && exp_run > 0) check("line_enb_run", run, exp_run);
        run = 0;
      end
    end
  end

  // One frame. len==0 means end_line never comes; abort_off/rst_off are cycles after the
  // first ACTIVE cycle (negative = not used); disturb adds a mid-frame start/test toggle and
  // an end_line pulse during the first BLANK.
  task automatic run_frame(input bit tm, input int len, input int abort_off, input int rst_off,
                           input bit disturb);
    int s, n, per, cut, lim, k, exp_idx;
    bit stop;
    n   = tm ? LT : LN;
    per = len + HBLANK;
    lim = (len == 0) ? TO + 50 : n * per + 50;
    @(negedge clk);
    s   = cyc + 1;
    cut = (abort_off >= 0) ? s + abort_off : ((rst_off >= 0) ? s + rst_off : 32'h7fffffff);
    if (len == 0) begin
      push(0, s, 0, tm, cut);
      push(2, s + TO, 0, tm, cut);
    end else begin
      for (int i = 0; i < n; i++) push(0, s + i * per, i, tm, cut);
      push(1, s + n * per, n - 1, tm, cut);
    end
    exp_run  = (abort_off >= 0 || rst_off >= 0) ? -1 : ((len == 0) ? TO : len);
    line_len = len;
    bus.start = 1'b1;
    bus.test  = tm;
    bus.abort = 1'b0;
    stop = 1'b0;
    k = 0;
    while (!stop) begin
      @(negedge clk);
      k++;
      bus.start = 1'b0;
      bus.abort = 1'b0;
      el_force  = 1'b0;
      if (cyc == s) check("err_clear_on_start", int'(bus.timeout_err), 0);
      if (disturb && cyc == s + 2) begin
        bus.start = 1'b1;
        bus.test  = !tm;
      end
      if (disturb && len > 0 && cyc == s + len + 3) el_force = 1'b1;
      if (abort_off >= 0 && cyc == s + abort_off) bus.abort = 1'b1;
      if (abort_off >= 0 && cyc == s + abort_off + 1) begin
        exp_idx = (abort_off / per < n) ? abort_off / per : n - 1;
        check("abort_line_enb", int'(bus.line_enb), 0);
        check("abort_busy", int'(bus.busy), 0);
        check("abort_frame_done", int'(bus.frame_done), 0);
        check("abort_line_idx", int'(bus.line_idx), exp_idx);
        stop = 1'b1;
      end
      if (rst_off >= 0 && cyc == s + rst_off) begin
        rst_n = 1'b0;
        #1;
        check("rst_line_enb", int'(bus.line_enb), 0);
        check("rst_test_mode", int'(bus.test_mode), 0);
        check("rst_line_idx", int'(bus.line_idx), 0);
        check("rst_line_start", int'(bus.line_start), 0);
        check("rst_frame_done", int'(bus.frame_done), 0);
        check("rst_busy", int'(bus.busy), 0);
        check("rst_timeout_err", int'(bus.timeout_err), 0);
        stop = 1'b1;
      end
      if (!stop && cyc > s && !bus.busy) begin
        check("idle_idx_hold", int'(bus.line_idx), (len == 0) ? 0 : n - 1);
        check("idle_mode_hold", int'(bus.test_mode), int'(tm));
        check("idle_timeout_err", int'(bus.timeout_err), (len == 0) ? 1 : 0);
        stop = 1'b1;
      end
      if (!stop && k > lim) begin
        check("frame_cycle_bound", k, lim);
        stop = 1'b1;
      end
    end
    if (rst_off >= 0) begin
      @(negedge clk);
      rst_n = 1'b1;
    end
    @(negedge clk);
    #1;
    check("queue_drained", exp_q.size(), 0);
    exp_q.delete();
  endtask

  initial begin
    #1_500_000;
    $display("FAIL global_time_limit: got %0d cycles, expected completion", cyc);
    $fatal(1, "simulation time limit");
  end

  initial begin
    int tm, len, n, ab;
    bus.start = 1'b0;
    bus.test  = 1'b0;
    bus.abort = 1'b0;
    repeat (2) @(negedge clk);
    #1;
    check("reset_line_enb", int'(bus.line_enb), 0);
    check("reset_busy", int'(bus.busy), 0);
    check("reset_line_idx", int'(bus.line_idx), 0);
    check("reset_timeout_err", int'(bus.timeout_err), 0);
    @(negedge clk);
    rst_n = 1'b1;

    // abort in IDLE blocks start
    @(negedge clk);
    bus.start = 1'b1;
    bus.abort = 1'b1;
    bus.test  = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    bus.abort = 1'b0;
    check("abort_blocks_start", int'(bus.busy), 0);

    run_frame(1'b1, 1290, -1, -1, 1'b1);               // test-mode frame, 8 lines
    run_frame(1'b0, 4096, -1, -1, 1'b0);               // normal frame, 2 lines
    run_frame(1'b0, TO, -1, -1, 1'b0);                 // end_line on the watchdog limit
    run_frame(1'b1, 0, -1, -1, 1'b0);                  // watchdog timeout
    run_frame(1'b1, 20, 3 * (20 + HBLANK) + 5, -1, 1'b1);  // abort during line 3
    run_frame(1'b0, 25, -1, 25 + 4, 1'b0);             // reset during BLANK
    run_frame(1'b0, 10, -1, -1, 1'b1);                 // fresh frame after reset

    for (int f = 0; f < 10; f++) begin
      tm  = $urandom_range(0, 1);
      len = $urandom_range(1, 40);
      n   = tm ? LT : LN;
      ab  = ($urandom_range(0, 2) == 0) ? $urandom_range(1, n * (len + HBLANK) - 1) : -1;
      run_frame(tm[0], len, ab, -1, (ab < 0 || ab > len + 4));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end
endmodule

// File: doc/line_scan_ctrl.md
LINE_SCAN_CTRL -- requirements
Module: line_scan_ctrl

Interface
REQ-001 Parameter HBLANK_CYC, default 16: idle cycles between lines, legal range 1..255.
REQ-002 Parameter LINES_NORMAL, default 3072: lines per frame in normal mode, legal range 1..4096.
REQ-003 Parameter LINES_TEST, default 8: lines per frame in test mode, legal range 1..4096.
REQ-004 Parameter TIMEOUT_CYC, default 4104: maximum ACTIVE cycles allowed without end_line.
REQ-005 Port clk, input, 1 bit: clock; all logic is rising-edge triggered.
REQ-006 Port rst_n, input, 1 bit: reset, asynchronous, active-low.
REQ-007 Port start, input, 1 bit: frame request; sampled only in IDLE.
REQ-008 Port test, input, 1 bit: 1 selects test mode, 0 selects normal mode; sampled only with an accepted start.
REQ-009 Port abort, input, 1 bit: synchronous frame cancel.
REQ-010 Port end_line, input, 1 bit: end-of-line flag from the 12-bit pixel counter.
REQ-011 Port line_enb, output, 1 bit: enable to the pixel counter; low clears that counter.
REQ-012 Port test_mode, output, 1 bit: latched mode, forwarded to the pixel counter test input.
REQ-013 Port line_idx, output, 12 bits: index of the current line.
REQ-014 Port line_start, output, 1 bit: one-cycle pulse on the first ACTIVE cycle of each line.
REQ-015 Port frame_done, output, 1 bit: one-cycle pulse on frame completion.
REQ-016 Port busy, output, 1 bit: high in every state except IDLE.
REQ-017 Port timeout_err, output, 1 bit: sticky error flag.

Function
REQ-018 FSM states SHALL be IDLE, ACTIVE, BLANK and DONE; all outputs SHALL be registered.
REQ-019 In IDLE with start=1 and abort=0, the block SHALL latch test into test_mode, clear line_idx to 0, clear timeout_err, and enter ACTIVE on the next cycle.
REQ-020 line_enb SHALL be 1 exactly while the state is ACTIVE, and 0 otherwise.
REQ-021 line_start SHALL be 1 for exactly one cycle, on the first cycle of every ACTIVE period.
REQ-022 In ACTIVE, end_line=1 SHALL cause a transition to BLANK on the next cycle and SHALL load the blank counter with HBLANK_CYC-1.
REQ-023 In BLANK, the blank counter SHALL decrement once per cycle; when it is 0 the state SHALL change on the next cycle.
REQ-024 On BLANK exit, if line_idx equals last_line the next state SHALL be DONE; otherwise line_idx SHALL increment by 1 and the next state SHALL be ACTIVE.
REQ-025 last_line SHALL be LINES_TEST-1 when test_mode=1 and LINES_NORMAL-1 otherwise.
REQ-026 Each line SHALL therefore occupy its ACTIVE cycles plus exactly HBLANK_CYC cycles of BLANK.
REQ-027 DONE SHALL last exactly one cycle with frame_done=1 and SHALL then return to IDLE.
REQ-028 line_idx and test_mode SHALL hold their values in IDLE until the next accepted start.
REQ-029 A 13-bit watchdog SHALL clear on ACTIVE entry and increment every ACTIVE cycle.
REQ-030 If the watchdog reaches TIMEOUT_CYC-1 without end_line, timeout_err SHALL set and the state SHALL go to IDLE with no frame_done.
REQ-031 abort=1 in any non-IDLE state SHALL force IDLE on the next cycle with no frame_done pulse; abort has priority over end_line and the timeout.
REQ-032 abort=1 in IDLE SHALL block start.
REQ-033 start in any non-IDLE state SHALL be ignored.
REQ-034 Changes on test after a start is accepted SHALL NOT affect test_mode until the next accepted start.
REQ-035 end_line SHALL be ignored outside ACTIVE.
REQ-036 If end_line and watchdog expiry occur in the same cycle, end_line SHALL win and timeout_err SHALL NOT set.

Reset
REQ-037 While rst_n=0, the block SHALL be in IDLE with line_enb=0, test_mode=0, line_idx=0, line_start=0, frame_done=0, busy=0, timeout_err=0, and the blank counter and watchdog cleared.
REQ-038 Reset asserted mid-frame SHALL take effect immediately and asynchronously; the first start after release SHALL begin a fresh frame at line 0.

Verification
REQ-039 Test-mode frame: LINES_TEST=8, HBLANK_CYC=16, test=1, end_line driven by a 1290-count pixel counter model -> 8 line_start pulses, line_idx counts 0..7, exactly one frame_done, and 8*(1290+16)+2 cycles from start to frame_done, within ±2 cycles.
REQ-040 Normal-mode frame: LINES_NORMAL=2 -> line_enb high for 4096 cycles per line, and frame_done after the second BLANK.
REQ-041 Abort: abort pulsed during line 3 of a test-mode frame -> IDLE next cycle, line_enb=0, no frame_done, and line_idx holds 3.
REQ-042 Timeout: end_line held 0 after start -> timeout_err=1 at ACTIVE cycle 4104, busy=0, and a following start clears timeout_err.
REQ-043 Mode latch and ignored start: test toggled and start pulsed mid-frame -> test_mode unchanged and no restart; end_line pulsed in BLANK -> no effect.
REQ-044 Reset mid-frame: rst_n pulsed low during BLANK -> all outputs at reset values immediately, without waiting for a clock edge.
